// File: rtl/ex_mem_if.sv
// ex_mem_if -- signal bundle between the ID/EX stage, the writeback forwarding
// source and the EX/MEM pipeline stage.
//   master : the pipeline around the stage (drives EX operands/control, W
//            forwarding source and stallM; observes redirect and M outputs)
//   slave  : ex_mem_stage itself
interface ex_mem_if;
    // EX-stage instruction
    logic        validE;
    logic [31:0] rs1E, rs2E, immE, pcE;
    logic [4:0]  rs1nE, rs2nE, rdnE;
    logic        RegWriteE;
    logic [1:0]  ResultSrcE;
    logic        MemWriteE;
    logic [2:0]  ALUControlE;
    logic        ALUSrcE, BranchE, JumpE;
    // writeback forwarding source
    logic [4:0]  rdnW;
    logic        RegWriteW;
    logic [31:0] ResultW;
    // memory back-pressure
    logic        stallM;
    // redirect (combinational)
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    // EX/MEM register outputs
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  rdnM;
    logic        RegWriteM;
    logic [1:0]  ResultSrcM;
    logic        MemWriteM;
    logic        validM;

    modport master (
        output validE, rs1E, rs2E, immE, pcE, rs1nE, rs2nE, rdnE,
               RegWriteE, ResultSrcE, MemWriteE, ALUControlE, ALUSrcE, BranchE, JumpE,
               rdnW, RegWriteW, ResultW, stallM,
        input  PCSrcE, PCTargetE, ALUResultM, WriteDataM, PCPlus4M,
               rdnM, RegWriteM, ResultSrcM, MemWriteM, validM
    );

    modport slave (
        input  validE, rs1E, rs2E, immE, pcE, rs1nE, rs2nE, rdnE,
               RegWriteE, ResultSrcE, MemWriteE, ALUControlE, ALUSrcE, BranchE, JumpE,
               rdnW, RegWriteW, ResultW, stallM,
        output PCSrcE, PCTargetE, ALUResultM, WriteDataM, PCPlus4M,
               rdnM, RegWriteM, ResultSrcM, MemWriteM, validM
    );
endinterface

// File: rtl/ex_mem_stage.sv
// ex_mem_stage -- execute stage (forwarding, ALU, branch resolve) plus the
// EX/MEM pipeline register and a saturating taken-redirect counter.
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset, wins over stallM
//   bus          : ex_mem_if.slave -- EX inputs, W forwarding source, stallM,
//                  combinational redirect (PCSrcE/PCTargetE), registered M outputs
//   redirect_cnt : number of taken redirects accepted (stallM=0), saturating
module ex_mem_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    ex_mem_if.slave          bus,
    output logic [CNT_W-1:0] redirect_cnt
);

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] write_data;
        logic [31:0] pc_plus4;
        logic [4:0]  rdn;
        logic        reg_write;
        logic [1:0]  result_src;
        logic        mem_write;
        logic        valid;
    } ex_mem_t;

    ex_mem_t          m_q, m_d;
    logic [CNT_W-1:0] redirect_cnt_q, redirect_cnt_d;

    logic [31:0] src_a, fwd_b, src_b, alu_result;
    logic        zero, pc_src;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        src_a          = bus.rs1E;
        fwd_b          = bus.rs2E;
        src_b          = '0;
        alu_result     = '0;
        zero           = 1'b0;
        pc_src         = 1'b0;
        m_d            = m_q;
        redirect_cnt_d = redirect_cnt_q;

        // Forwarding: the held M instruction is younger than W, so it wins.
        if (m_q.reg_write && m_q.valid && m_q.rdn != 5'd0 && m_q.rdn == bus.rs1nE)
            src_a = m_q.alu_result;
        else if (bus.RegWriteW && bus.rdnW != 5'd0 && bus.rdnW == bus.rs1nE)
            src_a = bus.ResultW;

        if (m_q.reg_write && m_q.valid && m_q.rdn != 5'd0 && m_q.rdn == bus.rs2nE)
            fwd_b = m_q.alu_result;
        else if (bus.RegWriteW && bus.rdnW != 5'd0 && bus.rdnW == bus.rs2nE)
            fwd_b = bus.ResultW;

        src_b = bus.ALUSrcE ? bus.immE : fwd_b;

        case (alu_op_e'(bus.ALUControlE))
            ALU_ADD: alu_result = src_a + src_b;
            ALU_SUB: alu_result = src_a - src_b;
            ALU_AND: alu_result = src_a & src_b;
            ALU_OR:  alu_result = src_a | src_b;
            ALU_XOR: alu_result = src_a ^ src_b;
            ALU_SLT: alu_result = {31'd0, $signed(src_a) < $signed(src_b)};
            ALU_SLL: alu_result = src_a << src_b[4:0];
            ALU_SRL: alu_result = src_a >> src_b[4:0];
            default: alu_result = '0;
        endcase

        zero   = (alu_result == 32'd0);
        pc_src = bus.validE & (bus.JumpE | (bus.BranchE & zero));

        if (rst) begin
            m_d            = '0;
            redirect_cnt_d = '0;
        end else if (!bus.stallM) begin
            // Bubbles still load their data fields; only the qualifiers matter.
            m_d.alu_result = alu_result;
            m_d.write_data = fwd_b;
            m_d.pc_plus4   = bus.pcE + 32'd4;
            m_d.rdn        = bus.rdnE;
            m_d.reg_write  = bus.RegWriteE & bus.validE;
            m_d.result_src = bus.ResultSrcE;
            m_d.mem_write  = bus.MemWriteE & bus.validE;
            m_d.valid      = bus.validE;
            // A redirect during a stall is re-presented afterwards, so count only here.
            if (pc_src && redirect_cnt_q != {CNT_W{1'b1}})
                redirect_cnt_d = redirect_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    always_ff @(posedge clk) begin
        m_q            <= m_d;
        redirect_cnt_q <= redirect_cnt_d;
    end

    assign bus.PCSrcE     = pc_src;
    assign bus.PCTargetE  = bus.pcE + bus.immE;
    assign bus.ALUResultM = m_q.alu_result;
    assign bus.WriteDataM = m_q.write_data;
    assign bus.PCPlus4M   = m_q.pc_plus4;
    assign bus.rdnM       = m_q.rdn;
    assign bus.RegWriteM  = m_q.reg_write;
    assign bus.ResultSrcM = m_q.result_src;
    assign bus.MemWriteM  = m_q.mem_write;
    assign bus.validM     = m_q.valid;
    assign redirect_cnt   = redirect_cnt_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage -- randomized + directed bench for ex_mem_stage against a
// transaction-level reference model. Two instances run the same stimulus:
// dut_a with the default 16-bit counter, dut_b with a 2-bit counter.
module tb_ex_mem_stage;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_mem_if bus_a ();
    ex_mem_if bus_b ();
    logic [15:0] cnt_a_o;
    logic [1:0]  cnt_b_o;

    ex_mem_stage #(.CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(bus_a), .redirect_cnt(cnt_a_o));
    ex_mem_stage #(.CNT_W(2))  dut_b (.clk(clk), .rst(rst), .bus(bus_b), .redirect_cnt(cnt_b_o));

    // dut_b mirrors dut_a's inputs
    assign bus_b.validE      = bus_a.validE;
    assign bus_b.rs1E        = bus_a.rs1E;
    assign bus_b.rs2E        = bus_a.rs2E;
    assign bus_b.immE        = bus_a.immE;
    assign bus_b.pcE         = bus_a.pcE;
    assign bus_b.rs1nE       = bus_a.rs1nE;
    assign bus_b.rs2nE       = bus_a.rs2nE;
    assign bus_b.rdnE        = bus_a.rdnE;
    assign bus_b.RegWriteE   = bus_a.RegWriteE;
    assign bus_b.ResultSrcE  = bus_a.ResultSrcE;
    assign bus_b.MemWriteE   = bus_a.MemWriteE;
    assign bus_b.ALUControlE = bus_a.ALUControlE;
    assign bus_b.ALUSrcE     = bus_a.ALUSrcE;
    assign bus_b.BranchE     = bus_a.BranchE;
    assign bus_b.JumpE       = bus_a.JumpE;
    assign bus_b.rdnW        = bus_a.rdnW;
    assign bus_b.RegWriteW   = bus_a.RegWriteW;
    assign bus_b.ResultW     = bus_a.ResultW;
    assign bus_b.stallM      = bus_a.stallM;

    typedef struct {
        logic        rst, stall, valid;
        logic [31:0] rs1, rs2, imm, pc;
        logic [4:0]  rs1n, rs2n, rdn;
        logic        rw;
        logic [1:0]  rsrc;
        logic        mw;
        logic [2:0]  aluc;
        logic        alusrc, br, jmp;
        logic [4:0]  rdnw;
        logic        rww;
        logic [31:0] resw;
    } ex_t;

    // Reference state: what the M stage currently holds, as a transaction.
    typedef struct {
        logic [31:0] alu, wd, pc4;
        logic [4:0]  rd;
        logic        rw;
        logic [1:0]  rsrc;
        logic        mw, v;
    } m_t;

    m_t m;
    bit data_known;   // data fields are defined (after reset or a real instruction)
    int exp_cnt_a, exp_cnt_b;
    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic ex_t idle();
        ex_t t;
        t = '{default: '0};
        return t;
    endfunction

    function automatic ex_t rand_ex();
        ex_t t;
        t.rst    = ($urandom_range(0, 40) == 0);
        t.stall  = ($urandom_range(0, 3) == 0);
        t.valid  = ($urandom_range(0, 4) != 0);
        t.rs1    = $urandom;
        t.rs2    = ($urandom_range(0, 3) == 0) ? t.rs1 : $urandom;
        t.imm    = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 64)) : $urandom;
        t.pc     = $urandom & 32'hFFFF_FFFC;
        t.rs1n   = 5'($urandom_range(0, 3));
        t.rs2n   = 5'($urandom_range(0, 3));
        t.rdn    = 5'($urandom_range(0, 3));
        t.rw     = 1'($urandom);
        t.rsrc   = 2'($urandom);
        t.mw     = 1'($urandom);
        t.aluc   = 3'($urandom);
        t.alusrc = 1'($urandom);
        t.br     = 1'($urandom);
        t.jmp    = ($urandom_range(0, 7) == 0);
        t.rdnw   = 5'($urandom_range(0, 3));
        t.rww    = 1'($urandom);
        t.resw   = $urandom;
        return t;
    endfunction

    // Most recent writer of a register wins; x0 never forwards.
    function automatic logic [31:0] operand(input logic [4:0] rn, input logic [31:0] reg_val, input ex_t t);
        if (m.v && m.rw && rn != 0 && m.rd == rn) return m.alu;
        if (t.rww && rn != 0 && t.rdnw == rn)     return t.resw;
        return reg_val;
    endfunction

    function automatic logic [31:0] alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0: return 32'(longint'(a) + longint'(b));
            3'd1: return 32'(longint'(a) - longint'(b) + 64'h1_0000_0000);
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return (sa < sb) ? 32'd1 : 32'd0;
            3'd6: return 32'(longint'(a) * (longint'(1) << b[4:0]));
            default: return 32'(longint'(a) / (longint'(1) << b[4:0]));
        endcase
    endfunction

    task automatic apply(input ex_t t);
        logic [31:0] a, wb, res, tgt;
        logic        take;
        @(negedge clk);
        rst                 = t.rst;
        bus_a.stallM        = t.stall;
        bus_a.validE        = t.valid;
        bus_a.rs1E          = t.rs1;
        bus_a.rs2E          = t.rs2;
        bus_a.immE          = t.imm;
        bus_a.pcE           = t.pc;
        bus_a.rs1nE         = t.rs1n;
        bus_a.rs2nE         = t.rs2n;
        bus_a.rdnE          = t.rdn;
        bus_a.RegWriteE     = t.rw;
        bus_a.ResultSrcE    = t.rsrc;
        bus_a.MemWriteE     = t.mw;
        bus_a.ALUControlE   = t.aluc;
        bus_a.ALUSrcE       = t.alusrc;
        bus_a.BranchE       = t.br;
        bus_a.JumpE         = t.jmp;
        bus_a.rdnW          = t.rdnw;
        bus_a.RegWriteW     = t.rww;
        bus_a.ResultW       = t.resw;
        #1;
        a    = operand(t.rs1n, t.rs1, t);
        wb   = operand(t.rs2n, t.rs2, t);
        res  = alu(t.aluc, a, t.alusrc ? t.imm : wb);
        take = t.valid && (t.jmp || (t.br && res == 0));
        tgt  = 32'(longint'(t.pc) + longint'(t.imm));
        check("pcsrc",  {31'd0, bus_a.PCSrcE}, {31'd0, take});
        check("target", bus_a.PCTargetE, tgt);
        check("pcsrc_b", {31'd0, bus_b.PCSrcE}, {31'd0, take});

        @(posedge clk);
        if (t.rst) begin
            m = '{default: '0};
            data_known = 1;
            exp_cnt_a = 0;
            exp_cnt_b = 0;
        end else if (!t.stall) begin
            m.alu  = res;
            m.wd   = wb;
            m.pc4  = 32'(longint'(t.pc) + 4);
            m.rd   = t.rdn;
            m.rsrc = t.rsrc;
            m.v    = t.valid;
            m.rw   = t.rw && t.valid;
            m.mw   = t.mw && t.valid;
            data_known = t.valid;
            if (take) begin
                if (exp_cnt_a < 65535) exp_cnt_a++;
                if (exp_cnt_b < 3)     exp_cnt_b++;
            end
        end
        #1;
        check("validM",    {31'd0, bus_a.validM},    {31'd0, m.v});
        check("regwriteM", {31'd0, bus_a.RegWriteM}, {31'd0, m.rw});
        check("memwriteM", {31'd0, bus_a.MemWriteM}, {31'd0, m.mw});
        if (data_known) begin
            check("aluresM", bus_a.ALUResultM, m.alu);
            check("wdataM",  bus_a.WriteDataM, m.wd);
            check("pc4M",    bus_a.PCPlus4M,   m.pc4);
            check("rdnM",    {27'd0, bus_a.rdnM},       {27'd0, m.rd});
            check("rsrcM",   {30'd0, bus_a.ResultSrcM}, {30'd0, m.rsrc});
        end
        check("cnt_a", {16'd0, cnt_a_o}, 32'(exp_cnt_a));
        check("cnt_b", {30'd0, cnt_b_o}, 32'(exp_cnt_b));
        check("validM_b", {31'd0, bus_b.validM}, {31'd0, m.v});
    endtask

    initial begin
        ex_t t;
        m = '{default: '0};
        data_known = 1;
        exp_cnt_a = 0;
        exp_cnt_b = 0;

        // reset with stall asserted: reset wins
        t = idle(); t.rst = 1; t.stall = 1;
        apply(t);
        check("rst_valid", {31'd0, bus_a.validM}, 32'd0);
        check("rst_alu",   bus_a.ALUResultM, 32'd0);

        // 5 + 7 via immediate
        t = idle(); t.valid = 1; t.rs1 = 5; t.imm = 7; t.alusrc = 1; t.rw = 1; t.rdn = 3;
        t.rs1n = 9;
        apply(t);
        check("add_imm", bus_a.ALUResultM, 32'd12);
        check("add_rw",  {31'd0, bus_a.RegWriteM}, 32'd1);

        // x3 <- 0x10, then a consumer of x3 with a competing W write of 0x99
        t = idle(); t.valid = 1; t.rs1 = 32'h10; t.alusrc = 1; t.rw = 1; t.rdn = 3; t.rs1n = 9;
        apply(t);
        t = idle(); t.valid = 1; t.rs1 = 32'h55; t.rs1n = 3; t.alusrc = 1;
        t.rdnw = 3; t.rww = 1; t.resw = 32'h99;
        apply(t);
        check("fwd_m_prio", bus_a.ALUResultM, 32'h10);

        // writes to x0 never forward
        t = idle(); t.valid = 1; t.rs1 = 32'h77; t.rw = 1; t.rdn = 0; t.alusrc = 1; t.rs1n = 9;
        apply(t);
        t = idle(); t.valid = 1; t.rs1 = 32'h55; t.rs1n = 0; t.alusrc = 1;
        apply(t);
        check("no_fwd_x0", bus_a.ALUResultM, 32'h55);

        // taken branch on equal operands, negative offset
        t = idle(); t.valid = 1; t.br = 1; t.aluc = 3'b001; t.rs1 = 32'h1234; t.rs2 = 32'h1234;
        t.rs1n = 9; t.rs2n = 10; t.pc = 32'h100; t.imm = 32'hFFFF_FFF0;
        apply(t);
        check("br_cnt", {16'd0, cnt_a_o}, 32'd1);
        check("br_tgt", bus_a.PCTargetE, 32'hF0);

        // stall for 3 cycles while EX changes, then release
        for (int i = 0; i < 3; i++) begin
            t = rand_ex(); t.rst = 0; t.stall = 1; t.jmp = 1; t.valid = 1;
            apply(t);
        end
        t = idle(); t.valid = 1; t.rs1 = 32'hABC; t.alusrc = 1; t.rs1n = 9;
        apply(t);
        check("post_stall", bus_a.ALUResultM, 32'hABC);

        // bubble carrying a store
        t = idle(); t.valid = 0; t.mw = 1; t.rw = 1;
        apply(t);

        // 2-bit counter saturates after 5 jumps
        t = idle(); t.rst = 1;
        apply(t);
        for (int i = 0; i < 5; i++) begin
            t = idle(); t.valid = 1; t.jmp = 1;
            apply(t);
        end
        check("sat_b", {30'd0, cnt_b_o}, 32'd3);
        check("cnt_a5", {16'd0, cnt_a_o}, 32'd5);

        // reset in the middle of a stall clears the held instruction
        t = idle(); t.valid = 1; t.rw = 1; t.mw = 1; t.rdn = 4;
        apply(t);
        t = idle(); t.stall = 1;
        apply(t);
        t = idle(); t.stall = 1; t.rst = 1;
        apply(t);
        check("rst_stall_v", {31'd0, bus_a.validM}, 32'd0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            apply(rand_ex());
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the taken-redirect counter.
REQ-002 SHALL have clk input 1: clock, all state updates on its rising edge.
REQ-003 SHALL have rst input 1: reset, synchronous, active-high.
REQ-004 SHALL have validE input 1: the instruction in EX is real (0 = bubble).
REQ-005 SHALL have rs1E, rs2E, immE, pcE inputs, 32 bits each: operands, immediate and PC from ID/EX.
REQ-006 SHALL have rs1nE, rs2nE, rdnE inputs, 5 bits each: source and destination register numbers.
REQ-007 SHALL have RegWriteE (1), ResultSrcE (2), MemWriteE (1), ALUControlE (3), ALUSrcE (1), BranchE (1) and JumpE (1) inputs: control from ID/EX.
REQ-008 SHALL have rdnW (5), RegWriteW (1) and ResultW (32) inputs: writeback-stage forwarding source.
REQ-009 SHALL have stallM input 1: hold the EX/MEM register (memory busy).
REQ-010 SHALL have PCSrcE (1) and PCTargetE (32) outputs: redirect request and target, combinational.
REQ-011 SHALL have ALUResultM, WriteDataM and PCPlus4M outputs, 32 bits each, registered.
REQ-012 SHALL have rdnM (5), RegWriteM (1), ResultSrcM (2), MemWriteM (1) and validM (1) outputs, registered.
REQ-013 SHALL have redirect_cnt output, CNT_W bits: count of taken redirects.

Function
REQ-014 Forward A SHALL select ALUResultM when RegWriteM & validM & rdnM!=0 & rdnM==rs1nE; otherwise ResultW when RegWriteW & rdnW!=0 & rdnW==rs1nE; otherwise rs1E.
REQ-015 Forward B SHALL apply the same rule with rs2nE; the M-stage match takes priority over the W-stage match.
REQ-016 SrcB SHALL be immE when ALUSrcE=1, else forwarded B; WriteData SHALL always be forwarded B.
REQ-017 ALU SHALL implement ALUControlE: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT signed (result 0/1), 110 SLL, 111 SRL, with shift amount SrcB[4:0]; results are modulo 2^32.
REQ-018 Zero SHALL be 1 iff the ALU result is 0.
REQ-019 PCSrcE SHALL be validE & (JumpE | (BranchE & Zero)).
REQ-020 PCTargetE SHALL be pcE+immE modulo 2^32.
REQ-021 EX/MEM register: when stallM=0, it SHALL capture ALU result, WriteData, pcE+4, rdnE, ResultSrcE and validE on each clock edge, with RegWriteM=RegWriteE&validE and MemWriteM=MemWriteE&validE.
REQ-022 When stallM=1, all registered outputs SHALL hold their values.
REQ-023 When stallM=1, forwarding SHALL still use the held M values.
REQ-024 A bubble (validE=0) SHALL load validM=0, RegWriteM=0 and MemWriteM=0; the data fields are don't-care.
REQ-025 Latency SHALL be 1 cycle from EX inputs to M outputs; PCSrcE and PCTargetE SHALL be 0-cycle.
REQ-026 redirect_cnt SHALL increment on each edge where PCSrcE=1 and stallM=0.
REQ-027 redirect_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-028 A redirect under stallM=1 SHALL NOT be counted; the upstream holds EX during the stall.

Reset
REQ-029 When rst=1 at a clock edge, all registered outputs and redirect_cnt SHALL become 0, including validM.
REQ-030 rst SHALL take priority over stallM.
REQ-031 Reset mid-stall SHALL clear the pending M instruction.
REQ-032 PCSrcE SHALL be purely combinational and unaffected by rst.

Verification
REQ-033 Scenario: rs1E=5, immE=7, ALUSrcE=1, ALUControlE=000, validE=1 -> ALUResultM=12 one cycle later, RegWriteM follows RegWriteE.
REQ-034 Scenario: back-to-back dependency, rdnM=3 with RegWriteM=1 and ALUResultM=0x10, rs1nE=3, rdnW=3 with ResultW=0x99 -> forwarded A=0x10 (M priority).
REQ-035 Scenario: rdnM=0, RegWriteM=1, rs1nE=0 -> no forwarding; rs1E is used.
REQ-036 Scenario: BranchE=1, ALUControlE=001, equal operands, pcE=0x100, immE=0xFFFFFFF0 -> PCSrcE=1, PCTargetE=0xF0, redirect_cnt increments by 1.
REQ-037 Scenario: stallM=1 for 3 cycles while EX inputs change -> M outputs are constant and the counter is frozen; after release the next EX instruction is captured.
REQ-038 Scenario: validE=0 with MemWriteE=1 -> MemWriteM=0 and validM=0; CNT_W=2 with 5 jumps -> redirect_cnt=3; rst asserted during stall -> all outputs 0.
